// File: rtl/input_buffer_ctrl_pkg.sv
// Shared constants and helpers for the input-buffer controller.
package inbuf_pkg;

    localparam int unsigned INBUF_DATA_WIDTH = 32;
    localparam int unsigned OBUF_DEPTH       = 2;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/input_buffer_ctrl_if.sv
// Producer, FIFO and drain-stream signals of the input-buffer controller.
interface input_buffer_ctrl_if #(
    parameter int unsigned DATA_WIDTH = inbuf_pkg::INBUF_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = 4
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_cs;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_rd_cs;
    logic                          fifo_rd_en;
    logic [DATA_WIDTH-1:0]         fifo_data_out;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_ready;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_empty, fifo_data_out, out_ready,
        output req_ready, fifo_wr_cs, fifo_wr_en, fifo_data_in, fifo_rd_cs, fifo_rd_en,
               out_valid, out_data
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_empty, fifo_data_out, out_ready,
        input  req_ready, fifo_wr_cs, fifo_wr_en, fifo_data_in, fifo_rd_cs, fifo_rd_en,
               out_valid, out_data
    );
endinterface

// File: rtl/input_buffer_ctrl_rr_arbiter.sv
// Round-robin write arbiter owning rr_ptr.
// INBUF_CTRL_PRIO_EN: requester 0 wins outright and leaves rr_ptr untouched.
module rr_arbiter import inbuf_pkg::*; #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 en,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [REQ_IDX_W-1:0] gnt_idx
);
    logic [REQ_IDX_W-1:0] rr_ptr;
    logic                 gnt_any;
    logic                 prio_hit;
    int unsigned          idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        prio_hit = 1'b0;
        idx      = 0;
`ifdef INBUF_CTRL_PRIO_EN
        if (en && req[0]) begin
            gnt[0]   = 1'b1;
            gnt_any  = 1'b1;
            prio_hit = 1'b1;
        end
`endif
        // With req[0] idle the full search naturally covers only 1..NUM_REQ-1
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (en && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = REQ_IDX_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (gnt_any && !prio_hit) begin
            rr_ptr <= REQ_IDX_W'(rr_next(32'(gnt_idx), NUM_REQ));
        end
    end
endmodule

// File: rtl/input_buffer_ctrl.sv
// Shares the input-buffer FIFO between producers and drains it through a 2-entry buffer.
// INBUF_CTRL_PRIO_EN selects strict priority for requester 0 (see rr_arbiter).
module input_buffer_ctrl import inbuf_pkg::*; #(
    parameter int unsigned DATA_WIDTH = INBUF_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned REQ_IDX_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input_buffer_ctrl_if.master bus
);
    logic [NUM_REQ-1:0]    gnt;
    logic [REQ_IDX_W-1:0]  gnt_idx;
    logic                  wr_en;
    logic                  rd_en;
    logic                  pop;
    logic                  inflight;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] obuf0;
    logic [DATA_WIDTH-1:0] obuf1;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .en      (rst && !bus.fifo_full),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign wr_en            = |gnt;
    assign bus.req_ready    = gnt;
    assign bus.fifo_wr_cs   = wr_en;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = wr_en ? bus.req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign bus.out_valid = (buf_cnt != 2'd0);
    assign bus.out_data  = obuf0;
    assign pop           = bus.out_valid && bus.out_ready;

    // Reserve a slot for the word in flight; a pop this cycle frees one
    assign rd_en = rst && !bus.fifo_empty &&
                   (({1'b0, buf_cnt} + {2'b0, inflight}) < (3'(OBUF_DEPTH) + {2'b0, pop}));
    assign bus.fifo_rd_cs = rd_en;
    assign bus.fifo_rd_en = rd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            buf_cnt  <= '0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            inflight <= rd_en;
            case ({inflight, pop})
                2'b11: begin
                    if (buf_cnt == 2'(OBUF_DEPTH)) begin
                        obuf0 <= obuf1;
                        obuf1 <= bus.fifo_data_out;
                    end else begin
                        obuf0 <= bus.fifo_data_out;
                    end
                end
                2'b01: begin
                    obuf0   <= obuf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) obuf0 <= bus.fifo_data_out;
                    else                 obuf1 <= bus.fifo_data_out;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Directed bench for input_buffer_ctrl with a 64-entry FIFO model (full at 63 words).
module tb_input_buffer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_buffer_ctrl_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus ();

    input_buffer_ctrl #(.DATA_WIDTH(32), .NUM_REQ(4), .REQ_IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pword(input int unsigned i, input int unsigned c);
        return {4'(i), 28'(c)};
    endfunction

    // FIFO model: registered flags, one-cycle read latency, pointers move unconditionally
    logic [31:0] mem [64];
    logic [5:0]  wp, rp;
    logic [6:0]  fcnt;
    logic [31:0] dout;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0; rp <= '0; fcnt <= '0; dout <= '0;
        end else begin
            if (bus.fifo_wr_en) begin
                mem[wp] <= bus.fifo_data_in;
                wp      <= wp + 6'd1;
            end
            if (bus.fifo_rd_en) begin
                dout <= mem[rp];
                rp   <= rp + 6'd1;
            end
            fcnt <= fcnt + 7'(bus.fifo_wr_en) - 7'(bus.fifo_rd_en);
        end
    end
    assign bus.fifo_full     = (fcnt >= 7'd63);
    assign bus.fifo_empty    = (fcnt == 7'd0);
    assign bus.fifo_data_out = dout;

    // Producers: each emits {id, running count}, advancing on acceptance
    int unsigned prod_cnt [4] = '{0, 0, 0, 0};
    logic        man_en   = 1'b0;
    logic [31:0] man_word = '0;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) prod_cnt[i] <= prod_cnt[i] + 1;
        end
    end
    always_comb begin
        for (int i = 0; i < 4; i++)
            bus.req_data[i*32 +: 32] = man_en ? man_word : pword(i, prod_cnt[i]);
    end

    // Monitors
    int unsigned wr_count = 0, wr_full_viol = 0, rd_empty_viol = 0, cs_viol = 0, stab_viol = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    logic [31:0] got_q [$];
    always @(posedge clk) begin
        if (!rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (bus.fifo_wr_en) wr_count++;
            if (bus.fifo_wr_en && bus.fifo_full) wr_full_viol++;
            if (bus.fifo_rd_en && bus.fifo_empty) rd_empty_viol++;
            if (bus.fifo_wr_cs != bus.fifo_wr_en || bus.fifo_rd_cs != bus.fifo_rd_en) cs_viol++;
            if (hold_pend && (!bus.out_valid || bus.out_data != hold_data)) stab_viol++;
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            hold_pend <= bus.out_valid && !bus.out_ready;
            hold_data <= bus.out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected %0d", 0, 1);
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        man_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_words(input int unsigned qb, input int unsigned n, input int unsigned budget);
        for (int unsigned c = 0; c < budget && got_q.size() < qb + n; c++) @(negedge clk);
    endtask

    int unsigned qb, b0, w0, v0, e0, s0, strobes;
    logic [31:0] exp_q [$];

    initial begin
        // Reset state with every producer requesting
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        @(negedge clk); #1;
        check_val("rst_req_ready", 32'(bus.req_ready), 0);
        check_val("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check_val("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        check_val("rst_out_valid", 32'(bus.out_valid), 0);
        check_val("rst_out_data", bus.out_data, 0);

        // Read latency: strobe at t, out_valid only at t+2
        do_reset();
        man_en = 1'b1; man_word = 32'hDEADBEEF; bus.out_ready = 1'b1;
        bus.req_valid = 4'b0010;
        #1;
        check_val("lat_grant", 32'(bus.req_ready), 32'h2);
        check_val("lat_wdata", bus.fifo_data_in, 32'hDEADBEEF);
        @(negedge clk); bus.req_valid = '0; #1;
        check_val("lat_strobe", 32'(bus.fifo_rd_en), 1);
        @(negedge clk); #1;
        check_val("lat_t1_valid", 32'(bus.out_valid), 0);
        check_val("lat_t1_strobe", 32'(bus.fifo_rd_en), 0);
        @(negedge clk); #1;
        check_val("lat_t2_valid", 32'(bus.out_valid), 1);
        check_val("lat_t2_data", bus.out_data, 32'hDEADBEEF);
        @(negedge clk); #1;
        check_val("lat_t3_valid", 32'(bus.out_valid), 0);
        man_en = 1'b0;

        // Round robin, all producers valid
        do_reset();
        bus.out_ready = 1'b1;
        qb = got_q.size();
        exp_q.delete();
        for (int unsigned k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            bus.req_valid = 4'hF;
            exp_q.push_back(pword(k % 4, prod_cnt[k % 4]));
            #1;
            check_val("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            check_val("rr_wdata", bus.fifo_data_in, exp_q[k]);
        end
        @(negedge clk); bus.req_valid = '0;
        wait_words(qb, 8, 50);
        check_val("rr_count", got_q.size() - qb, 8);
        for (int unsigned k = 0; k < 8 && qb + k < got_q.size(); k++)
            check_val("rr_order", got_q[qb + k], exp_q[k]);

        // Full backpressure
        do_reset();
        w0 = wr_count; v0 = wr_full_viol;
        b0 = prod_cnt[0];
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (80) @(negedge clk);
        #1;
        check_val("full_req_ready", 32'(bus.req_ready), 0);
        check_val("full_flag", 32'(bus.fifo_full), 1);
        check_val("full_fifo_cnt", 32'(fcnt), 63);
        check_val("full_writes", wr_count - w0, 65);
        check_val("full_out_valid", 32'(bus.out_valid), 1);
        check_val("full_no_wr", wr_full_viol - v0, 0);
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        qb = got_q.size();
        wait_words(qb, 65, 200);
        check_val("full_drain_cnt", got_q.size() - qb, 65);
        for (int unsigned k = 0; k < 65 && qb + k < got_q.size(); k++)
            if (k % 16 == 0 || k == 64)
                check_val("full_drain_word", got_q[qb + k], pword(k % 4, prod_cnt[k % 4] - 16 + k / 4 - (k % 4 == 0 ? 1 : 0)));

        // Stall and burst: 10 words from producer 2, out_ready 1,0,0,...
        do_reset();
        e0 = rd_empty_viol; s0 = stab_viol;
        b0 = prod_cnt[2];
        bus.req_valid = 4'b0100;
        repeat (10) @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        qb = got_q.size();
        for (int unsigned c = 0; c < 100 && got_q.size() < qb + 10; c++) begin
            bus.out_ready = (c % 3 == 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_val("stall_count", got_q.size() - qb, 10);
        for (int unsigned k = 0; k < 10 && qb + k < got_q.size(); k++)
            check_val("stall_word", got_q[qb + k], pword(2, b0 + k));
        check_val("stall_no_empty_rd", rd_empty_viol - e0, 0);
        check_val("stall_hold", stab_viol - s0, 0);
        check_val("stall_idle", 32'(bus.out_valid), 0);

        // Reset mid-operation, in the cycle after the second read strobe
        do_reset();
        bus.req_valid = 4'b0001;
        strobes = 0;
        for (int unsigned c = 0; c < 20 && strobes < 2; c++) begin
            @(negedge clk); #1;
            if (bus.fifo_rd_en) strobes++;
        end
        check_val("mid_strobes", strobes, 2);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check_val("mid_req_ready", 32'(bus.req_ready), 0);
        check_val("mid_wr_en", 32'(bus.fifo_wr_en), 0);
        check_val("mid_rd_en", 32'(bus.fifo_rd_en), 0);
        check_val("mid_out_valid", 32'(bus.out_valid), 0);
        check_val("mid_out_data", bus.out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        qb = got_q.size();
        b0 = prod_cnt[3];
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1000;
        repeat (3) @(negedge clk);
        bus.req_valid = '0;
        wait_words(qb, 3, 30);
        repeat (10) @(negedge clk);
        check_val("mid_count", got_q.size() - qb, 3);
        for (int unsigned k = 0; k < 3 && qb + k < got_q.size(); k++)
            check_val("mid_word", got_q[qb + k], pword(3, b0 + k));

        // Requesters 0 and 2 both valid, then 0 drops
        do_reset();
        bus.out_ready = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clk);
            bus.req_valid = 4'b0101;
            #1;
`ifdef INBUF_CTRL_PRIO_EN
            check_val("prio_grant", 32'(bus.req_ready), 32'h1);
`else
            check_val("rr02_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
`endif
        end
        @(negedge clk);
        bus.req_valid = 4'b0100;
        #1;
        check_val("prio_drop_grant", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (10) @(negedge clk);
        check_val("cs_match", cs_viol, 0);
        check_val("no_empty_rd_total", rd_empty_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
